// File: rtl/shake_pkg.sv
// shake_pkg: shared SHAKE256 constants and squeeze sequencer state encoding
package shake_pkg;
  localparam int RATE_BITS  = 1088;
  localparam int LANE_W     = 64;
  localparam int RATE_LANES = RATE_BITS / LANE_W;
  localparam int ROUNDS     = 24;
  typedef enum logic [2:0] {IDLE, STREAM, PERM_REQ, PERM_WAIT, DONE} squeeze_state_t;
endpackage

// File: rtl/shake_squeeze_ctrl.sv
// shake_squeeze_ctrl: streams requested SHAKE256 output lanes, re-permuting after each full rate block
module shake_squeeze_ctrl
  import shake_pkg::*;
#(
  parameter int RATE_LANES = 17,
  parameter int LANE_W     = 64,
  parameter int LEN_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  out_lanes,
  output logic              perm_start,
  input  logic              perm_done,
  output logic [4:0]        lane_sel,
  input  logic [LANE_W-1:0] lane_data,
  output logic [LANE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);
  squeeze_state_t   state;
  logic [LEN_W-1:0] remaining;
  assign dout = dout_valid ? lane_data : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      lane_sel   <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      perm_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (out_lanes != '0) begin
            state      <= STREAM;
            remaining  <= out_lanes;
            lane_sel   <= '0;
            dout_valid <= 1'b1;
            dout_last  <= out_lanes == LEN_W'(1);
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        STREAM: if (dout_ready) begin
          remaining <= remaining - LEN_W'(1);
          // the final lane never triggers a permutation, even at lane 16
          if (remaining == LEN_W'(1)) begin
            state      <= DONE;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            done       <= 1'b1;
          end else if (lane_sel == 5'(RATE_LANES - 1)) begin
            state      <= PERM_REQ;
            lane_sel   <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            perm_start <= 1'b1;
          end else begin
            lane_sel  <= lane_sel + 5'd1;
            dout_last <= remaining == LEN_W'(2);
          end
        end
        PERM_REQ: begin
          state      <= PERM_WAIT;
          perm_start <= 1'b0;
        end
        PERM_WAIT: if (perm_done) begin
          state      <= STREAM;
          dout_valid <= 1'b1;
          dout_last  <= remaining == LEN_W'(1);
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shake_squeeze_ctrl.sv
// tb_shake_squeeze_ctrl: directed checks of the squeeze sequencer against a 24-cycle permutation model
module tb_shake_squeeze_ctrl;
  logic        clock = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [15:0] out_lanes = 0;
  logic        perm_start;
  logic        perm_done;
  logic [4:0]  lane_sel;
  logic [63:0] lane_data;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1;
  logic        dout_last;
  logic        busy;
  logic        done;
  logic        model_done = 0;
  logic        stray_done = 0;
  int          perm_cnt = 0;
  int          perm_pulses = 0;
  int          perm_base = 0;
  int          cnt = 0;
  int          checks = 0;
  int          fails = 0;

  shake_squeeze_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .out_lanes(out_lanes),
    .perm_start(perm_start), .perm_done(perm_done), .lane_sel(lane_sel),
    .lane_data(lane_data), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // state datapath: lane content encodes block number and lane index
  assign perm_done = model_done | stray_done;
  assign lane_data = {16'hABCD, 16'(perm_cnt - perm_base), 27'd0, lane_sel};

  always @(posedge clock) begin
    if (reset) begin
      cnt        <= 0;
      model_done <= 0;
    end else begin
      model_done <= (cnt == 1);
      if (perm_start) cnt <= 24;
      else if (cnt != 0) cnt <= cnt - 1;
    end
    if (perm_done) perm_cnt <= perm_cnt + 1;
    if (perm_start) perm_pulses <= perm_pulses + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input int n, input bit bp, input bit noise);
    int beat = 0, guard = 0, p0;
    bit want_ps = 0, fresh = 0, stalled = 0, pd_prev = 0;
    logic [4:0]  last_sel = 0;
    logic [63:0] last_dout = 0;
    @(negedge clock);
    start = 1; out_lanes = 16'(n); perm_base = perm_cnt; p0 = perm_pulses;
    @(negedge clock);
    start = 0;
    chk("busy_after_start", 64'(busy), 64'd1);
    if (n == 0) begin
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_valid", 64'(dout_valid), 64'd0);
      @(negedge clock);
      chk("zero_done_clr", 64'(done), 64'd0);
      chk("zero_busy_clr", 64'(busy), 64'd0);
      chk("zero_valid2", 64'(dout_valid), 64'd0);
      return;
    end
    chk("first_valid", 64'(dout_valid), 64'd1);
    while (beat < n && guard < 2000) begin
      guard++;
      if (want_ps) begin
        chk("perm_start_after_blk", 64'(perm_start), 64'd1);
        chk("valid_low_in_perm", 64'(dout_valid), 64'd0);
        want_ps = 0;
      end
      if (dout_valid) begin
        if (stalled) begin
          chk("stall_lane_sel", 64'(lane_sel), 64'(last_sel));
          chk("stall_dout", dout, last_dout);
        end
        if (fresh) begin
          chk("resume_after_perm_done", 64'(pd_prev), 64'd1);
          fresh = 0;
        end
        chk("lane_sel", 64'(lane_sel), 64'(beat % 17));
        chk("dout", dout, {16'hABCD, 16'(beat / 17), 27'd0, 5'(beat % 17)});
        chk("dout_last", 64'(dout_last), 64'(beat == n - 1));
      end
      pd_prev = perm_done;
      dout_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start = noise && ($urandom_range(0, 3) == 0);
      out_lanes = 16'd3;
      last_sel = lane_sel;
      last_dout = dout;
      stalled = dout_valid && !dout_ready;
      if (dout_valid && dout_ready) begin
        if (beat % 17 == 16 && beat != n - 1) begin
          want_ps = 1;
          fresh = 1;
        end
        beat++;
      end
      if (beat < n) @(negedge clock);
    end
    chk("beat_count", 64'(beat), 64'(n));
    @(negedge clock);
    dout_ready = 1;
    start = noise;
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd1);
    chk("valid_in_done", 64'(dout_valid), 64'd0);
    @(negedge clock);
    start = 0;
    chk("done_clr", 64'(done), 64'd0);
    chk("busy_clr", 64'(busy), 64'd0);
    chk("perm_pulses", 64'(perm_pulses - p0), 64'((n - 1) / 17));
  endtask

  initial begin
    int g;
    repeat (3) @(negedge clock);
    reset = 0;
    chk("rst_lane_sel", 64'(lane_sel), 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_outs", {59'd0, dout_valid, dout_last, perm_start, busy, done}, 64'd0);
    run_req(5, 0, 0);
    run_req(17, 0, 0);
    run_req(18, 0, 0);
    run_req(0, 0, 0);
    run_req(40, 1, 1);
    // abandon a request while the permutation is in flight
    @(negedge clock);
    start = 1; out_lanes = 16'd18; perm_base = perm_cnt;
    @(negedge clock);
    start = 0;
    g = 0;
    while (!perm_start && g < 100) begin
      g++;
      @(negedge clock);
    end
    chk("reach_perm_req", 64'(perm_start), 64'd1);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("rst2_lane_sel", 64'(lane_sel), 64'd0);
    chk("rst2_dout", dout, 64'd0);
    chk("rst2_outs", {59'd0, dout_valid, dout_last, perm_start, busy, done}, 64'd0);
    stray_done = 1;
    @(negedge clock);
    stray_done = 0;
    repeat (3) begin
      @(negedge clock);
      chk("stray_no_beat", 64'(dout_valid), 64'd0);
      chk("stray_idle", 64'(busy), 64'd0);
    end
    run_req(3, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
